// File: rtl/alu_result_reader_if.sv
// Handshake bundle between the ALU core, the result unloader and the output sink.
// out_parity exists only when ALU_RESULT_READER_PARITY_EN is defined.
interface alu_result_reader_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] q_in;
  logic              busy;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              done;
`ifdef ALU_RESULT_READER_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    input  load, a_in, q_in, out_ready,
    output busy, out_data, out_valid, out_last, done
`ifdef ALU_RESULT_READER_PARITY_EN
    , output out_parity
`endif
  );

  modport slave (
    output load, a_in, q_in, out_ready,
    input  busy, out_data, out_valid, out_last, done
`ifdef ALU_RESULT_READER_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/alu_result_reader.sv
// Snapshots A/Q in one cycle and streams them as two valid/ready beats.
// Optional registered even parity on each beat: define ALU_RESULT_READER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for load; out_data keeps the last beat
// BEAT0 | first half offered (A, or Q when LSB_FIRST)
// BEAT1 | second half offered, out_last high
// DONE  | one-cycle done pulse, load ignored
module alu_result_reader #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_hold_q, q_hold_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] first_beat, second_beat;
  logic              capture, advance;
  logic              busy, out_valid, out_last, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.load)      state_d = S_BEAT0;
      S_BEAT0: if (bus.out_ready) state_d = S_BEAT1;
      S_BEAT1: if (bus.out_ready) state_d = S_DONE;
      S_DONE:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    out_last  = (state_q == S_BEAT1);
    done      = (state_q == S_DONE);
  end

  // First beat comes straight from the inputs so it is valid the cycle after load.
  assign capture     = (state_q == S_IDLE) && bus.load;
  assign advance     = (state_q == S_BEAT0) && bus.out_ready;
  assign first_beat  = LSB_FIRST ? bus.q_in : bus.a_in;
  assign second_beat = LSB_FIRST ? a_hold_q : q_hold_q;

  always_comb begin
    data_d = data_q;
    if (capture)      data_d = first_beat;
    else if (advance) data_d = second_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold_q <= '0;
      q_hold_q <= '0;
      data_q   <= '0;
    end else begin
      if (capture) begin
        a_hold_q <= bus.a_in;
        q_hold_q <= bus.q_in;
      end
      data_q <= data_d;
    end
  end

`ifdef ALU_RESULT_READER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^data_d;
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.done      = done;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_alu_result_reader.sv
// Directed bench for alu_result_reader: MSB-first and LSB-first instances side by side.
// Status word is {busy, out_valid, out_last, done, out_data}.
module tb_alu_result_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [11:0] exp_st;

  always #5 clk = ~clk;

  alu_result_reader_if #(.DATA_W(8)) bm ();
  alu_result_reader_if #(.DATA_W(8)) bl ();

  alu_result_reader #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bm));
  alu_result_reader #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bl));

  logic [11:0] st_m, st_l;
  assign st_m = {bm.busy, bm.out_valid, bm.out_last, bm.done, bm.out_data};
  assign st_l = {bl.busy, bl.out_valid, bl.out_last, bl.done, bl.out_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bm.load = 0; bm.a_in = 0; bm.q_in = 0; bm.out_ready = 0;
    bl.load = 0; bl.a_in = 0; bl.q_in = 0; bl.out_ready = 0;
    #1 rst = 1'b1;
    #2;
    n_total++;
    if (st_m !== 12'h000) $display("FAIL reset_msb: got %h want %h", st_m, 12'h000);
    else n_pass++;
    n_total++;
    if (st_l !== 12'h000) $display("FAIL reset_lsb: got %h want %h", st_l, 12'h000);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bm.out_parity !== 1'b0) $display("FAIL reset_parity: got %b want 0", bm.out_parity);
    else n_pass++;
`endif
    step();
    rst = 1'b0;
    // ready without a pending beat must not start anything
    bm.out_ready = 1;
    step();
    step();
    n_total++;
    if (st_m[11:8] !== 4'b0000) $display("FAIL idle_ready_noeffect: got %b want 0000", st_m[11:8]);
    else n_pass++;
  endtask

  task automatic test_basic();
    bm.a_in = 8'hA5; bm.q_in = 8'h3C; bm.out_ready = 1; bm.load = 1;
    step();
    bm.load = 0;
    exp_st = {4'b1100, 8'hA5};
    n_total++;
    if (st_m !== exp_st) $display("FAIL basic_beat0: got %h want %h", st_m, exp_st);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bm.out_parity !== 1'b0) $display("FAIL basic_par0: got %b want 0", bm.out_parity);
    else n_pass++;
`endif
    step();
    exp_st = {4'b1110, 8'h3C};
    n_total++;
    if (st_m !== exp_st) $display("FAIL basic_beat1: got %h want %h", st_m, exp_st);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bm.out_parity !== 1'b0) $display("FAIL basic_par1: got %b want 0", bm.out_parity);
    else n_pass++;
`endif
    step();
    n_total++;
    if (st_m[11:8] !== 4'b1001) $display("FAIL basic_done: got %b want 1001", st_m[11:8]);
    else n_pass++;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b0000) $display("FAIL basic_idle: got %b want 0000", st_m[11:8]);
    else n_pass++;
  endtask

  task automatic test_stall();
    bm.a_in = 8'hA5; bm.q_in = 8'h3C; bm.out_ready = 0; bm.load = 1;
    step();
    bm.load = 0;
    exp_st = {4'b1100, 8'hA5};
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (st_m !== exp_st) $display("FAIL stall_beat0_%0d: got %h want %h", i, st_m, exp_st);
      else n_pass++;
      if (i < 3) step();
    end
    bm.out_ready = 1;
    step();
    bm.out_ready = 0;
    exp_st = {4'b1110, 8'h3C};
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (st_m !== exp_st) $display("FAIL stall_beat1_%0d: got %h want %h", i, st_m, exp_st);
      else n_pass++;
      if (i < 2) step();
    end
    bm.out_ready = 1;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b1001) $display("FAIL stall_done_t8: got %b want 1001", st_m[11:8]);
    else n_pass++;
    step();
  endtask

  task automatic test_lsb_first();
    bl.a_in = 8'hFF; bl.q_in = 8'h01; bl.out_ready = 1; bl.load = 1;
    step();
    bl.load = 0;
    exp_st = {4'b1100, 8'h01};
    n_total++;
    if (st_l !== exp_st) $display("FAIL lsb_beat0: got %h want %h", st_l, exp_st);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bl.out_parity !== 1'b1) $display("FAIL lsb_par0: got %b want 1", bl.out_parity);
    else n_pass++;
`endif
    step();
    exp_st = {4'b1110, 8'hFF};
    n_total++;
    if (st_l !== exp_st) $display("FAIL lsb_beat1: got %h want %h", st_l, exp_st);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bl.out_parity !== 1'b0) $display("FAIL lsb_par1: got %b want 0", bl.out_parity);
    else n_pass++;
`endif
    step();
    n_total++;
    if (st_l[11:8] !== 4'b1001) $display("FAIL lsb_done: got %b want 1001", st_l[11:8]);
    else n_pass++;
    step();
  endtask

  task automatic test_load_ignored();
    bm.a_in = 8'hA5; bm.q_in = 8'h3C; bm.out_ready = 1; bm.load = 1;
    step();
    bm.load = 0;
    step();
    // in BEAT1: new load with fresh data, stalled one cycle
    bm.load = 1; bm.a_in = 8'h00; bm.q_in = 8'h00; bm.out_ready = 0;
    step();
    exp_st = {4'b1110, 8'h3C};
    n_total++;
    if (st_m !== exp_st) $display("FAIL ign_beat1_hold: got %h want %h", st_m, exp_st);
    else n_pass++;
    bm.out_ready = 1;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b1001) $display("FAIL ign_done: got %b want 1001", st_m[11:8]);
    else n_pass++;
    bm.a_in = 8'h11; bm.q_in = 8'h22;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b0000) $display("FAIL ign_done_load: got %b want 0000", st_m[11:8]);
    else n_pass++;
    step();
    bm.load = 0;
    exp_st = {4'b1100, 8'h11};
    n_total++;
    if (st_m !== exp_st) $display("FAIL ign_next_accept: got %h want %h", st_m, exp_st);
    else n_pass++;
    step();
    exp_st = {4'b1110, 8'h22};
    n_total++;
    if (st_m !== exp_st) $display("FAIL ign_next_beat1: got %h want %h", st_m, exp_st);
    else n_pass++;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    bm.a_in = 8'h12; bm.q_in = 8'h34; bm.out_ready = 0; bm.load = 1;
    step();
    bm.load = 0; bm.out_ready = 1;
    step();
    bm.out_ready = 0;
    step();
    exp_st = {4'b1110, 8'h34};
    n_total++;
    if (st_m !== exp_st) $display("FAIL rstmid_pre: got %h want %h", st_m, exp_st);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (st_m !== 12'h000) $display("FAIL rstmid_async: got %h want %h", st_m, 12'h000);
    else n_pass++;
`ifdef ALU_RESULT_READER_PARITY_EN
    n_total++;
    if (bm.out_parity !== 1'b0) $display("FAIL rstmid_parity: got %b want 0", bm.out_parity);
    else n_pass++;
`endif
    bm.out_ready = 1;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b0000) $display("FAIL rstmid_no_done: got %b want 0000", st_m[11:8]);
    else n_pass++;
    bm.a_in = 8'h5A; bm.q_in = 8'hC3; bm.load = 1;
    step();
    bm.load = 0;
    exp_st = {4'b1100, 8'h5A};
    n_total++;
    if (st_m !== exp_st) $display("FAIL rstmid_new0: got %h want %h", st_m, exp_st);
    else n_pass++;
    step();
    exp_st = {4'b1110, 8'hC3};
    n_total++;
    if (st_m !== exp_st) $display("FAIL rstmid_new1: got %h want %h", st_m, exp_st);
    else n_pass++;
    step();
    n_total++;
    if (st_m[11:8] !== 4'b1001) $display("FAIL rstmid_new_done: got %b want 1001", st_m[11:8]);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_lsb_first();
    test_load_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_result_reader.md
# alu_result_reader

Unload engine for the ALU datapath: captures the 16-bit result held in the accumulator (A) and quotient/multiplier (Q) registers in a single cycle. It then streams the result out as two 8-bit beats over a valid/ready handshake. It is the read-side counterpart of the parallel-load register file (A, Q, M), which is written with `en`. It sits between the ALU core and the output bus, and frees the core for the next operation once the snapshot is taken.

## Interface
Parameters:
- `DATA_W`, default 8: width of each register and of each output beat.
- `LSB_FIRST`, default 0: 0 sends A (high half) then Q (low half); 1 sends Q then A.

Ports:
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `load`, input, 1: capture request. Sampled only in IDLE.
- `a_in`, input, DATA_W: A register contents. Captured when `load` is accepted.
- `q_in`, input, DATA_W: Q register contents. Captured when `load` is accepted.
- `busy`, output, 1: high whenever the state is not IDLE.
- `out_data`, output, DATA_W: current beat.
- `out_valid`, output, 1: beat available.
- `out_ready`, input, 1: sink accepts the beat.
- `out_last`, output, 1: current beat is the second (final) beat.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.
- `out_parity`, output, 1: present only with the parity macro (see Configuration).

## Operation
- The FSM has four states: IDLE, BEAT0, BEAT1, DONE. All outputs are registered or decoded directly from state.
- IDLE:
  - `load`=1 captures `a_in` and `q_in` into internal hold registers, then goes to BEAT0.
  - `load`=0 stays in IDLE.
- BEAT0:
  - Drives `out_valid`=1, `out_last`=0.
  - `out_data` is A if `LSB_FIRST`=0, else Q.
  - Goes to BEAT1 on `out_valid && out_ready`; otherwise holds.
- BEAT1:
  - Drives `out_valid`=1, `out_last`=1, with the other half on `out_data`.
  - Goes to DONE on `out_ready`.
- DONE:
  - Drives `done`=1 and `out_valid`=0.
  - Goes unconditionally to IDLE.
- Handshake rules:
  - A transfer occurs only on a cycle where `out_valid`=1 and `out_ready`=1.
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `out_parity` are held stable.
  - `out_valid` never drops before a transfer.
- `out_ready` asserted while `out_valid`=0 has no effect.
- `load` is ignored in BEAT0, BEAT1 and DONE. It is not queued, and the hold registers are not overwritten mid-transfer.
- `a_in` and `q_in` changing after capture have no effect on the beats in flight.
- Reset values:
  - All outputs are 0: `busy`, `out_valid`, `out_last`, `done`, `out_data`, `out_parity`.
  - The state returns to IDLE and the hold registers clear to 0.
- Reset mid-transfer aborts immediately. No `done` is issued, and the remaining beat is discarded.
- When in IDLE, `out_data` shows the last-driven hold value; it is don't-care while `out_valid`=0.

## Timing
- `load` accepted at edge t gives `out_valid`=1 and `busy`=1 from t+1 (one-cycle latency).
- With `out_ready` held at 1:
  - beat 0 transfers at t+1 and beat 1 at t+2;
  - `done`=1 during t+3;
  - IDLE at t+4, and a new `load` is accepted at edge t+4.
- Minimum period between accepted loads is 4 cycles.
- Each cycle of `out_ready`=0 during BEAT0 or BEAT1 adds exactly one cycle.
- `done` is exactly one cycle wide. `busy` is high during DONE.
- `load` presented in the DONE cycle is ignored. `load` in the first IDLE cycle after DONE is accepted.

## Configuration
- Macro `ALU_RESULT_READER_PARITY_EN`.
- When defined:
  - the `out_parity` port exists;
  - it carries the even parity (XOR reduction) of the current `out_data`, registered with the beat;
  - it obeys the same stability rule as `out_data`.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then A=8'hA5, Q=8'h3C with `load` pulse and `out_ready`=1:
  - beats are 8'hA5 (`out_last`=0), then 8'h3C (`out_last`=1);
  - `done` pulses at t+3 and `busy` is low at t+4;
  - with parity enabled, `out_parity` is 0 then 0.
- Same stimulus, `out_ready` low for 3 cycles in BEAT0 and 2 cycles in BEAT1:
  - `out_data` is held stable during each stall;
  - `done` arrives at t+8.
- `LSB_FIRST`=1, A=8'hFF, Q=8'h01: beats are 8'h01 then 8'hFF. With parity, `out_parity` is 1 then 0.
- Second `load` with A=8'h00 during BEAT1, then during DONE: both are ignored. Captured data is still the first snapshot, and a load in the next IDLE is accepted.
- `rst` pulsed while stalled in BEAT1:
  - all outputs return to 0 asynchronously and no `done` is issued;
  - a new load after reset streams the correct new values.
